// File: rtl/seg7_capture.sv
// seg7_capture: recovers the hex nibble shown on each position of a multiplexed,
// active-low seven-segment bus. Inputs are synchronized, filtered by a
// stability window, decoded back to a nibble and stored per digit. Patterns
// that are neither a hex glyph nor blank raise an error pulse and are counted.
module seg7_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int IDX_W         = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    update,
    output logic                    err,
    output logic [IDX_W-1:0]        err_digit,
    output logic [7:0]              err_count
);

    // Counter only needs to reach STABLE_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam int SAMPLE_W = 7 + NUM_DIGITS;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } state_t;

    // Inverse of the hex-to-segment encoder: returns {hit, nibble}.
    function automatic logic [4:0] decode_glyph(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0011000: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b0000011: r = 5'h1B;
            7'b1000110: r = 5'h1C;
            7'b0100001: r = 5'h1D;
            7'b0000110: r = 5'h1E;
            7'b0001110: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    // True when exactly one digit enable is driven low.
    function automatic logic one_hot_low(input logic [NUM_DIGITS-1:0] a);
        int zeros;
        zeros = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!a[i]) zeros++;
        end
        return (zeros == 1);
    endfunction

    // Position of the low enable; only meaningful when one_hot_low() holds.
    function automatic logic [IDX_W-1:0] low_index(input logic [NUM_DIGITS-1:0] a);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!a[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    logic [6:0]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] an_s1, an_s2;
    logic [SAMPLE_W-1:0]   sample, prev_sample;
    logic                  changed, sel_ok, commit;
    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [4:0]            glyph;
    logic                  is_blank;
    logic [IDX_W-1:0]      idx;

    // Two-flop synchronizer on the asynchronous display bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            an_s1  <= '0;
            an_s2  <= '0;
        end else begin
            seg_s1 <= seg_n;
            seg_s2 <= seg_s1;
            an_s1  <= an_n;
            an_s2  <= an_s1;
        end
    end

    assign sample   = {seg_s2, an_s2};
    assign changed  = (sample != prev_sample);
    assign sel_ok   = one_hot_low(an_s2);
    assign glyph    = decode_glyph(seg_s2);
    assign is_blank = (seg_s2 == SEG_BLANK);
    assign idx      = low_index(an_s2);

    // Stability FSM state, counter and previous-sample registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            prev_sample <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            prev_sample <= sample;
        end
    end

    // Next-state logic: restart the window on any change, commit once when
    // the sample has been steady for the full window, then hold.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        if (!sel_ok) begin
            // No digit (or several) selected: nothing meaningful to capture.
            state_next = IDLE;
            cnt_next   = '0;
        end else if (changed || state == IDLE) begin
            state_next = COUNT;
            cnt_next   = '0;
        end else if (state == COUNT) begin
            if (cnt == CNT_LAST) begin
                commit     = 1'b1;
                state_next = HELD;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    // Per-digit capture registers, status pulses and error bookkeeping;
    // clear wins over a same-cycle commit and drops its pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value       <= '0;
            digit_valid <= '0;
            blank       <= '0;
            update      <= 1'b0;
            err         <= 1'b0;
            err_digit   <= '0;
            err_count   <= '0;
        end else begin
            update <= 1'b0;
            err    <= 1'b0;
            if (clear) begin
                value       <= '0;
                digit_valid <= '0;
                blank       <= '0;
                err_count   <= '0;
            end else if (commit) begin
                if (glyph[4]) begin
                    value[4*int'(idx) +: 4] <= glyph[3:0];
                    digit_valid[idx]        <= 1'b1;
                    blank[idx]              <= 1'b0;
                    update                  <= 1'b1;
                end else if (is_blank) begin
                    digit_valid[idx] <= 1'b0;
                    blank[idx]       <= 1'b1;
                    update           <= 1'b1;
                end else begin
                    digit_valid[idx] <= 1'b0;
                    blank[idx]       <= 1'b0;
                    err              <= 1'b1;
                    err_digit        <= idx;
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed, table-driven bench for seg7_capture with hand-computed expectations.
module tb_seg7_capture;

    localparam int ND = 4;
    localparam int SC = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [6:0]    seg_n;
    logic [ND-1:0] an_n;
    logic          clear;
    logic [4*ND-1:0] value;
    logic [ND-1:0] digit_valid;
    logic [ND-1:0] blank;
    logic          update;
    logic          err;
    logic [IW-1:0] err_digit;
    logic [7:0]    err_count;

    always #5 clk = ~clk;

    seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .IDX_W(IW)) dut (
        .clk(clk), .reset_n(reset_n), .seg_n(seg_n), .an_n(an_n), .clear(clear),
        .value(value), .digit_valid(digit_valid), .blank(blank), .update(update),
        .err(err), .err_digit(err_digit), .err_count(err_count)
    );

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  an;
        logic [15:0] val;
        logic [3:0]  vld;
        logic [3:0]  blk;
        logic [7:0]  ecnt;
        logic [1:0]  edig;
        int          upd;
        int          errp;
    } vec_t;

    vec_t tbl[22];

    int n_vec = 0;
    int n_bad = 0;
    int upd_seen = 0;
    int err_seen = 0;
    int both_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (update) upd_seen++;
        if (err) err_seen++;
        if (update && err) both_seen++;
    endtask

    function automatic vec_t mk(input logic [6:0] s, input logic [3:0] a, input logic [15:0] v,
                                input logic [3:0] vl, input logic [3:0] bl, input logic [7:0] ec,
                                input logic [1:0] ed, input int u, input int e);
        vec_t r;
        r.seg = s; r.an = a; r.val = v; r.vld = vl; r.blk = bl;
        r.ecnt = ec; r.edig = ed; r.upd = u; r.errp = e;
        return r;
    endfunction

    task automatic check_regs(input string tag, input logic [15:0] v, input logic [3:0] vl,
                              input logic [3:0] bl, input logic [7:0] ec);
        check({tag, " value"}, 32'(value), 32'(v));
        check({tag, " digit_valid"}, 32'(digit_valid), 32'(vl));
        check({tag, " blank"}, 32'(blank), 32'(bl));
        check({tag, " err_count"}, 32'(err_count), 32'(ec));
    endtask

    initial begin
        // Glyph scan on digit 2, then blank, error and mixed-digit rows.
        tbl[0]  = mk(7'b1000000, 4'b1011, 16'h0002, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[1]  = mk(7'b1111001, 4'b1011, 16'h0102, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[2]  = mk(7'b0100100, 4'b1011, 16'h0202, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[3]  = mk(7'b0110000, 4'b1011, 16'h0302, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[4]  = mk(7'b0011001, 4'b1011, 16'h0402, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[5]  = mk(7'b0010010, 4'b1011, 16'h0502, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[6]  = mk(7'b0000010, 4'b1011, 16'h0602, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[7]  = mk(7'b1111000, 4'b1011, 16'h0702, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[8]  = mk(7'b0000000, 4'b1011, 16'h0802, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[9]  = mk(7'b0011000, 4'b1011, 16'h0902, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[10] = mk(7'b0001000, 4'b1011, 16'h0A02, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[11] = mk(7'b0000011, 4'b1011, 16'h0B02, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[12] = mk(7'b1000110, 4'b1011, 16'h0C02, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[13] = mk(7'b0100001, 4'b1011, 16'h0D02, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[14] = mk(7'b0000110, 4'b1011, 16'h0E02, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[15] = mk(7'b0001110, 4'b1011, 16'h0F02, 4'b0101, 4'b0000, 8'd0, 2'd0, 1, 0);
        tbl[16] = mk(7'b1111111, 4'b1011, 16'h0F02, 4'b0001, 4'b0100, 8'd0, 2'd0, 1, 0);
        tbl[17] = mk(7'b1010101, 4'b1101, 16'h0F02, 4'b0001, 4'b0100, 8'd1, 2'd1, 0, 1);
        tbl[18] = mk(7'b0010010, 4'b1101, 16'h0F52, 4'b0011, 4'b0100, 8'd1, 2'd1, 1, 0);
        tbl[19] = mk(7'b1010101, 4'b1101, 16'h0F52, 4'b0001, 4'b0100, 8'd2, 2'd1, 0, 1);
        tbl[20] = mk(7'b1111000, 4'b0111, 16'h7F52, 4'b1001, 4'b0100, 8'd2, 2'd1, 1, 0);
        tbl[21] = mk(7'b0111111, 4'b0111, 16'h7F52, 4'b0001, 4'b0100, 8'd3, 2'd3, 0, 1);

        // Reset state
        reset_n = 1'b0;
        seg_n   = 7'b1111111;
        an_n    = 4'b1111;
        clear   = 1'b0;
        #12;
        check_regs("reset", 16'h0000, 4'b0000, 4'b0000, 8'd0);
        check("reset update", 32'(update), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset err_digit", 32'(err_digit), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) tick();

        // First capture: glyph 2 on digit 0, update exactly at edge SC+2
        seg_n = 7'b0100100;
        an_n  = 4'b1110;
        upd_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("first update edge%0d", k), 32'(update), 32'(k == SC + 2));
        end
        check_regs("first", 16'h0002, 4'b0001, 4'b0000, 8'd0);
        check("first pulses", 32'(upd_seen), 32'd1);

        // Table vectors, dwell 8 cycles each
        for (int i = 0; i < 22; i++) begin
            seg_n = tbl[i].seg;
            an_n  = tbl[i].an;
            upd_seen = 0;
            err_seen = 0;
            repeat (8) tick();
            check_regs($sformatf("row%0d", i), tbl[i].val, tbl[i].vld, tbl[i].blk, tbl[i].ecnt);
            check($sformatf("row%0d err_digit", i), 32'(err_digit), 32'(tbl[i].edig));
            check($sformatf("row%0d updates", i), 32'(upd_seen), 32'(tbl[i].upd));
            check($sformatf("row%0d errs", i), 32'(err_seen), 32'(tbl[i].errp));
        end

        // Error counter saturation: 300 further error commits on digit 1
        upd_seen = 0;
        err_seen = 0;
        an_n = 4'b1101;
        for (int i = 0; i < 300; i++) begin
            seg_n = i[0] ? 7'b0101010 : 7'b1010101;
            repeat (8) tick();
        end
        check("sat err_count", 32'(err_count), 32'd255);
        check("sat err pulses", 32'(err_seen), 32'd300);
        check("sat updates", 32'(upd_seen), 32'd0);
        check("sat err_digit", 32'(err_digit), 32'd1);

        // Clear wipes captured state but keeps err_digit
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        check_regs("clear", 16'h0000, 4'b0000, 4'b0000, 8'd0);
        check("clear err_digit", 32'(err_digit), 32'd1);

        // Glitching between 0 and 8 every 2 cycles, then steady 8
        upd_seen = 0;
        err_seen = 0;
        an_n = 4'b1110;
        for (int i = 0; i < 10; i++) begin
            seg_n = i[0] ? 7'b1000000 : 7'b0000000;
            repeat (2) tick();
        end
        check("glitch updates", 32'(upd_seen), 32'd0);
        check("glitch errs", 32'(err_seen), 32'd0);
        seg_n = 7'b0000000;
        repeat (10) tick();
        check("steady8 updates", 32'(upd_seen), 32'd1);
        check_regs("steady8", 16'h0008, 4'b0001, 4'b0000, 8'd0);

        // Invalid digit selects: two low, then none low
        upd_seen = 0;
        err_seen = 0;
        an_n  = 4'b1100;
        seg_n = 7'b0000000;
        repeat (20) tick();
        an_n  = 4'b1111;
        seg_n = 7'b1010101;
        repeat (20) tick();
        check("nosel updates", 32'(upd_seen), 32'd0);
        check("nosel errs", 32'(err_seen), 32'd0);
        check_regs("nosel", 16'h0008, 4'b0001, 4'b0000, 8'd0);

        // Clear on the very cycle the commit fires
        upd_seen = 0;
        err_seen = 0;
        an_n  = 4'b1110;
        seg_n = 7'b0110000;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 5) clear = 1'b1;
            if (k == 6) clear = 1'b0;
        end
        check("clrcommit updates", 32'(upd_seen), 32'd0);
        check("clrcommit errs", 32'(err_seen), 32'd0);
        check_regs("clrcommit", 16'h0000, 4'b0000, 4'b0000, 8'd0);
        repeat (10) tick();
        check("held no recommit", 32'(upd_seen), 32'd0);

        // Capture 6 on digit 0 so reset has something to wipe
        seg_n = 7'b0000010;
        repeat (8) tick();
        check_regs("pre-reset", 16'h0006, 4'b0001, 4'b0000, 8'd0);

        // Reset mid-count: asynchronous clear, then a full window
        seg_n = 7'b1111001;
        an_n  = 4'b0111;
        repeat (3) tick();
        reset_n = 1'b0;
        #2;
        check_regs("async reset", 16'h0000, 4'b0000, 4'b0000, 8'd0);
        check("async reset err_digit", 32'(err_digit), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        upd_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("post-reset update edge%0d", k), 32'(update), 32'(k == SC + 2));
        end
        check_regs("post-reset", 16'h1000, 4'b1000, 4'b0000, 8'd0);

        check("update and err together", 32'(both_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
